// File: rtl/apb_if.sv
// APB3 bus bundle between a requester (master) and a completer (slave).
// Clock and reset stay outside the bundle as plain ports.
interface apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_ram_slave.sv
// APB3 completer with a word-addressed RAM, programmable wait states and
// pslverr on addresses at or beyond DEPTH.
module apb_ram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic  i_clk,
    input  logic  i_presetn,
    apb_if.slave  apb
);
    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_setup;
    logic                  w_enter;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_in_range = (apb.paddr < ADDR_WIDTH'(DEPTH));
    assign w_idx      = apb.paddr[IDX_W-1:0];
    assign w_setup    = apb.psel && !apb.penable;
    assign w_rd_word  = (w_in_range && !apb.pwrite) ? r_mem[w_idx] : '0;

    // Edge that moves the FSM into ACCESS; the response registers load here.
    assign w_enter = ((r_state == ST_IDLE) && w_setup && (WS == 4'd0)) ||
                     ((r_state == ST_WAIT) && apb.psel && (r_cnt == 4'd1));

    always_ff @(posedge i_clk) begin
        if (!i_presetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_pready  <= w_enter;
            r_pslverr <= w_enter && !w_in_range;
            r_prdata  <= w_enter ? w_rd_word : '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        if (WS == 4'd0) begin
                            r_state <= ST_ACCESS;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!apb.psel) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    // pwdata is taken at the closing edge; out-of-range writes are dropped.
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    if (apb.psel && apb.penable && apb.pwrite && w_in_range) begin
                        r_mem[w_idx] <= apb.pwdata;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign apb.prdata  = r_prdata;
    assign apb.pready  = r_pready;
    assign apb.pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_ram_slave.sv
// Directed bench: three completers with 0, 2 and 3 wait states on one clock
// and reset, each driven by its own APB requester signals.
module tb_apb_ram_slave;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic presetn;
    always #5 clk = ~clk;

    logic        psel_d    [NDUT];
    logic        penable_d [NDUT];
    logic        pwrite_d  [NDUT];
    logic [31:0] paddr_d   [NDUT];
    logic [31:0] pwdata_d  [NDUT];
    logic [31:0] prdata_o  [NDUT];
    logic        pready_o  [NDUT];
    logic        pslverr_o [NDUT];

    int n_checks = 0;
    int n_errs   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.psel    = psel_d[g];
        assign bus.penable = penable_d[g];
        assign bus.pwrite  = pwrite_d[g];
        assign bus.paddr   = paddr_d[g];
        assign bus.pwdata  = pwdata_d[g];
        assign prdata_o[g]  = bus.prdata;
        assign pready_o[g]  = bus.pready;
        assign pslverr_o[g] = bus.pslverr;
        apb_ram_slave #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .DEPTH      (32),
            .WAIT_STATES(WS)
        ) u_dut (
            .i_clk    (clk),
            .i_presetn(presetn),
            .apb      (bus.slave)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle(input int s);
        psel_d[s]    = 1'b0;
        penable_d[s] = 1'b0;
        pwrite_d[s]  = 1'b0;
    endtask

    // One transfer; cycles counts clock cycles after setup up to and including the pready cycle.
    task automatic xfer(input int s, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int cycles, output int early_err);
        @(posedge clk); #1;
        psel_d[s]    = 1'b1;
        penable_d[s] = 1'b0;
        pwrite_d[s]  = wr;
        paddr_d[s]   = addr;
        pwdata_d[s]  = wdata;
        @(posedge clk); #1;
        penable_d[s] = 1'b1;
        cycles    = 0;
        early_err = 0;
        rdata     = '0;
        err       = 1'b0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (pready_o[s]) begin
                rdata = prdata_o[s];
                err   = pslverr_o[s];
                break;
            end
            if (pslverr_o[s]) early_err = 1;
        end
    endtask

    task automatic idle_check(input int s, input string tag);
        @(posedge clk); #1;
        bus_idle(s);
        @(negedge clk);
        check(tag, 32'(pready_o[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          ee;

        for (int s = 0; s < NDUT; s++) begin
            bus_idle(s);
            paddr_d[s]  = '0;
            pwdata_d[s] = '0;
        end
        presetn = 1'b0;

        // Test 1: reset state, then read addr 5
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < NDUT; s++) begin
            check($sformatf("rst_pready%0d", s), 32'(pready_o[s]), 32'd0);
            check($sformatf("rst_pslverr%0d", s), 32'(pslverr_o[s]), 32'd0);
            check($sformatf("rst_prdata%0d", s), prdata_o[s], 32'd0);
        end
        presetn = 1'b1;
        xfer(0, 1'b0, 32'd5, 32'd0, rd, er, cyc, ee);
        check("t1_rdata", rd, 32'd0);
        check("t1_err", 32'(er), 32'd0);
        check("t1_cycles", 32'(cyc), 32'd1);
        idle_check(0, "t1_pready_one_cycle");

        // Test 2: zero-wait write then back-to-back read
        xfer(0, 1'b1, 32'd3, 32'hDEADBEEF, rd, er, cyc, ee);
        check("t2_wr_cycles", 32'(cyc), 32'd1);
        check("t2_wr_err", 32'(er), 32'd0);
        check("t2_wr_prdata", rd, 32'd0);
        xfer(0, 1'b0, 32'd3, 32'd0, rd, er, cyc, ee);
        check("t2_rd_cycles", 32'(cyc), 32'd1);
        check("t2_rd_data", rd, 32'hDEADBEEF);
        xfer(0, 1'b1, 32'd31, 32'h0BADF00D, rd, er, cyc, ee);
        check("t2_top_wr_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'd31, 32'd0, rd, er, cyc, ee);
        check("t2_top_rd_data", rd, 32'h0BADF00D);
        check("t2_top_rd_err", 32'(er), 32'd0);
        idle_check(0, "t2_idle_pready");

        // Test 3: two wait states
        xfer(1, 1'b1, 32'd7, 32'hCAFEF00D, rd, er, cyc, ee);
        check("t3_wr_cycles", 32'(cyc), 32'd3);
        xfer(1, 1'b0, 32'd7, 32'd0, rd, er, cyc, ee);
        check("t3_rd_cycles", 32'(cyc), 32'd3);
        check("t3_rd_data", rd, 32'hCAFEF00D);
        check("t3_early_err", 32'(ee), 32'd0);
        idle_check(1, "t3_pready_only_once");

        // Test 4: out of range at DEPTH
        xfer(0, 1'b1, 32'd32, 32'h12345678, rd, er, cyc, ee);
        check("t4_wr_err", 32'(er), 32'd1);
        xfer(0, 1'b0, 32'd32, 32'd0, rd, er, cyc, ee);
        check("t4_rd_err", 32'(er), 32'd1);
        check("t4_rd_data", rd, 32'd0);
        xfer(0, 1'b0, 32'd0, 32'd0, rd, er, cyc, ee);
        check("t4_addr0_data", rd, 32'd0);
        check("t4_addr0_err", 32'(er), 32'd0);
        idle_check(0, "t4_idle_pslverr");
        check("t4_idle_pslverr_lvl", 32'(pslverr_o[0]), 32'd0);

        // Test 5: abort during wait states
        @(posedge clk); #1;
        psel_d[2] = 1'b1; penable_d[2] = 1'b0; pwrite_d[2] = 1'b1;
        paddr_d[2] = 32'd1; pwdata_d[2] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        penable_d[2] = 1'b1;
        @(negedge clk);
        check("t5_pready_T1", 32'(pready_o[2]), 32'd0);
        @(posedge clk); #1;
        bus_idle(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t5_pready_after_abort%0d", k), 32'(pready_o[2]), 32'd0);
        end
        xfer(2, 1'b0, 32'd1, 32'd0, rd, er, cyc, ee);
        check("t5_rd_data", rd, 32'd0);
        check("t5_rd_cycles", 32'(cyc), 32'd4);
        xfer(2, 1'b1, 32'd2, 32'h0000600D, rd, er, cyc, ee);
        xfer(2, 1'b0, 32'd2, 32'd0, rd, er, cyc, ee);
        check("t5_ws3_rd_data", rd, 32'h0000600D);
        idle_check(2, "t5_idle_pready");

        // Test 6: reset while in WAIT
        @(posedge clk); #1;
        psel_d[2] = 1'b1; penable_d[2] = 1'b0; pwrite_d[2] = 1'b1;
        paddr_d[2] = 32'd4; pwdata_d[2] = 32'h00000055;
        @(posedge clk); #1;
        penable_d[2] = 1'b1;
        @(negedge clk);
        presetn = 1'b0;
        @(negedge clk);
        check("t6_pready_in_reset", 32'(pready_o[2]), 32'd0);
        presetn = 1'b1;
        bus_idle(2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t6_pready_after_reset%0d", k), 32'(pready_o[2]), 32'd0);
        end
        xfer(2, 1'b0, 32'd4, 32'd0, rd, er, cyc, ee);
        check("t6_rd_addr4", rd, 32'd0);
        check("t6_rd_cycles", 32'(cyc), 32'd4);
        xfer(2, 1'b0, 32'd2, 32'd0, rd, er, cyc, ee);
        check("t6_rd_addr2_cleared", rd, 32'd0);
        idle_check(2, "t6_idle_pready");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
